// File: rtl/pong_pkg.sv
// Shared types and sizing for the pong game controller: phase encoding,
// counter widths and default game timing.
package pong_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned RALLY_W = 8;
  localparam int unsigned TIMER_W = 8;

  localparam int unsigned WIN_SCORE_DEF     = 5;
  localparam int unsigned NEWBALL_TICKS_DEF = 120;
  localparam int unsigned OVER_TICKS_DEF    = 180;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong controller and its surroundings
// (buttons, graphics events, score/text overlay).
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic [1:0]         btn1;
  logic [1:0]         btn2;
  logic               refr_tick;
  logic               hit;
  logic               miss_l;
  logic               miss_r;
  logic               graph_still;
  logic [1:0]         state_code;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [RALLY_W-1:0] rally;
  logic               serve_dir;
  logic               winner;
  logic               game_over;

  modport master (
    output btn1, btn2, refr_tick, hit, miss_l, miss_r,
    input  graph_still, state_code, score_l, score_r, rally,
           serve_dir, winner, game_over
  );

  modport slave (
    input  btn1, btn2, refr_tick, hit, miss_l, miss_r,
    output graph_still, state_code, score_l, score_r, rally,
           serve_dir, winner, game_over
  );

endinterface

// File: rtl/pong_tick_timer.sv
// Loadable frame-tick down-counter; holds at zero and flags expiry.
module pong_tick_timer
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  output logic               done_c_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // A load wins over a tick arriving in the same cycle.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c_o = (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: scores, rally, serve direction and game phases.
// Define PONG_AUTO_SERVE_EN to re-serve without a button press after a point.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = WIN_SCORE_DEF,
  parameter int unsigned NEWBALL_TICKS = NEWBALL_TICKS_DEF,
  parameter int unsigned OVER_TICKS    = OVER_TICKS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  pong_game_ctrl_if.slave  ctrl_if
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] NB_VAL  = TIMER_W'(NEWBALL_TICKS);
  localparam logic [TIMER_W-1:0] OV_VAL  = TIMER_W'(OVER_TICKS);

  state_e             state_q, state_d;
  logic               btn_any_c, btn_any_q, btn_rise_c;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SCORE_W-1:0] score_l_inc_c, score_r_inc_c;
  logic [RALLY_W-1:0] rally_q, rally_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               graph_still_q, graph_still_d;
  logic               game_over_q, game_over_d;
  logic               timer_load_c, timer_done_c;
  logic [TIMER_W-1:0] timer_val_c;

  assign btn_any_c     = |{ctrl_if.btn1, ctrl_if.btn2};
  assign btn_rise_c    = btn_any_c & ~btn_any_q;
  assign score_l_inc_c = score_l_q + SCORE_W'(1);
  assign score_r_inc_c = score_r_q + SCORE_W'(1);

  pong_tick_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timer_load_c),
    .load_val_i (timer_val_c),
    .tick_i     (ctrl_if.refr_tick),
    .done_c_o   (timer_done_c)
  );

  // btn_any_q resets high so a button held through reset is not seen as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_NEWGAME;
      btn_any_q     <= 1'b1;
      score_l_q     <= '0;
      score_r_q     <= '0;
      rally_q       <= '0;
      serve_dir_q   <= 1'b0;
      winner_q      <= 1'b0;
      graph_still_q <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_any_q     <= btn_any_c;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      rally_q       <= rally_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      graph_still_q <= graph_still_d;
      game_over_q   <= game_over_d;
    end
  end

  // Phase transitions and timer loading.
  always_comb begin
    state_d      = state_q;
    timer_load_c = 1'b0;
    timer_val_c  = NB_VAL;
    case (state_q)
      ST_NEWGAME: begin
        if (btn_rise_c) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (ctrl_if.miss_l && ctrl_if.miss_r) begin
          state_d      = ST_NEWBALL;
          timer_load_c = 1'b1;
        end else if (ctrl_if.miss_l || ctrl_if.miss_r) begin
          timer_load_c = 1'b1;
          if ((ctrl_if.miss_l && (score_r_inc_c == WIN_VAL)) ||
              (ctrl_if.miss_r && (score_l_inc_c == WIN_VAL))) begin
            state_d     = ST_OVER;
            timer_val_c = OV_VAL;
          end else begin
            state_d = ST_NEWBALL;
          end
        end
      end
      ST_NEWBALL: begin
`ifdef PONG_AUTO_SERVE_EN
        if (timer_done_c) state_d = ST_PLAY;
`else
        if (timer_done_c && btn_rise_c) state_d = ST_PLAY;
`endif
      end
      ST_OVER: begin
        if (timer_done_c) state_d = ST_NEWGAME;
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  // Score/rally/serve updates and phase-derived outputs.
  always_comb begin
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    rally_d     = rally_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      ST_NEWGAME: begin
        if (btn_rise_c) begin
          score_l_d = '0;
          score_r_d = '0;
          rally_d   = '0;
        end
      end
      ST_PLAY: begin
        if (ctrl_if.miss_l || ctrl_if.miss_r) begin
          rally_d = '0;
          if (ctrl_if.miss_l && !ctrl_if.miss_r) begin
            score_r_d   = score_r_inc_c;
            serve_dir_d = 1'b0;
            if (score_r_inc_c == WIN_VAL) winner_d = 1'b1;
          end else if (ctrl_if.miss_r && !ctrl_if.miss_l) begin
            score_l_d   = score_l_inc_c;
            serve_dir_d = 1'b1;
            if (score_l_inc_c == WIN_VAL) winner_d = 1'b0;
          end
        end else if (ctrl_if.hit && (rally_q != '1)) begin
          rally_d = rally_q + RALLY_W'(1);
        end
      end
      default: ;
    endcase
    graph_still_d = (state_d != ST_PLAY);
    game_over_d   = (state_d == ST_OVER);
  end

  assign ctrl_if.state_code  = state_q;
  assign ctrl_if.graph_still = graph_still_q;
  assign ctrl_if.score_l     = score_l_q;
  assign ctrl_if.score_r     = score_r_q;
  assign ctrl_if.rally       = rally_q;
  assign ctrl_if.serve_dir   = serve_dir_q;
  assign ctrl_if.winner      = winner_q;
  assign ctrl_if.game_over   = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: phases, scoring, same-cycle events,
// new-ball serve timing, game over and asynchronous reset.
module tb_pong_game_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  pong_game_ctrl_if bus ();

  pong_game_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refr_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.refr_tick = 1'b1;
      step();
      bus.refr_tick = 1'b0;
      step();
    end
  endtask

  task automatic event_pulse(input logic h, input logic ml, input logic mr);
    bus.hit    = h;
    bus.miss_l = ml;
    bus.miss_r = mr;
    step();
    bus.hit    = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
  endtask

  // From NEWBALL: let the 120-tick pause run out, then serve.
  task automatic serve_ball(input string tag);
    refr_pulses(120);
`ifdef PONG_AUTO_SERVE_EN
    step();
`else
    bus.btn2 = 2'b10;
    step();
    bus.btn2 = 2'b00;
`endif
    chk(tag, 32'(bus.state_code), 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.btn1      = 2'b01;
    bus.btn2      = 2'b00;
    bus.refr_tick = 1'b0;
    bus.hit       = 1'b0;
    bus.miss_l    = 1'b0;
    bus.miss_r    = 1'b0;
    step();
    step();

    chk("rst_state",     32'(bus.state_code),  32'd0);
    chk("rst_still",     32'(bus.graph_still), 32'd1);
    chk("rst_score_l",   32'(bus.score_l),     32'd0);
    chk("rst_score_r",   32'(bus.score_r),     32'd0);
    chk("rst_rally",     32'(bus.rally),       32'd0);
    chk("rst_serve",     32'(bus.serve_dir),   32'd0);
    chk("rst_winner",    32'(bus.winner),      32'd0);
    chk("rst_game_over", 32'(bus.game_over),   32'd0);

    // Button held through reset must not start the game.
    reset_n = 1'b1;
    step();
    step();
    chk("held_btn_no_start", 32'(bus.state_code), 32'd0);
    bus.btn1 = 2'b00;
    step();
    bus.btn1 = 2'b01;
    step();
    bus.btn1 = 2'b00;
    chk("start_state",   32'(bus.state_code),  32'd1);
    chk("start_still",   32'(bus.graph_still), 32'd0);
    chk("start_score_l", 32'(bus.score_l),     32'd0);
    chk("start_score_r", 32'(bus.score_r),     32'd0);

    // Three hits, then the left player misses.
    bus.hit = 1'b1;
    step();
    step();
    step();
    bus.hit = 1'b0;
    chk("rally3", 32'(bus.rally), 32'd3);
    event_pulse(1'b0, 1'b1, 1'b0);
    chk("missl_rally",   32'(bus.rally),       32'd0);
    chk("missl_score_r", 32'(bus.score_r),     32'd1);
    chk("missl_serve",   32'(bus.serve_dir),   32'd0);
    chk("missl_state",   32'(bus.state_code),  32'd2);
    chk("missl_still",   32'(bus.graph_still), 32'd1);

    // New-ball pause: early rise at tick 50 is discarded.
    refr_pulses(50);
    bus.btn2 = 2'b01;
    step();
    bus.btn2 = 2'b00;
    step();
    chk("early_rise_ignored", 32'(bus.state_code), 32'd2);
    refr_pulses(69);
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
    chk("tick120_still_nb", 32'(bus.state_code), 32'd2);
    step();
`ifdef PONG_AUTO_SERVE_EN
    chk("auto_serve", 32'(bus.state_code), 32'd1);
`else
    chk("wait_for_btn", 32'(bus.state_code), 32'd2);
    step();
    step();
    chk("wait_for_btn2", 32'(bus.state_code), 32'd2);
    bus.btn2 = 2'b01;
    step();
    bus.btn2 = 2'b00;
    chk("btn_serve", 32'(bus.state_code), 32'd1);
`endif
    chk("serve_still", 32'(bus.graph_still), 32'd0);

    // Both misses together: no score change.
    event_pulse(1'b1, 1'b0, 1'b0);
    event_pulse(1'b0, 1'b1, 1'b1);
    chk("dbl_score_l", 32'(bus.score_l),    32'd0);
    chk("dbl_score_r", 32'(bus.score_r),    32'd1);
    chk("dbl_serve",   32'(bus.serve_dir),  32'd0);
    chk("dbl_rally",   32'(bus.rally),      32'd0);
    chk("dbl_state",   32'(bus.state_code), 32'd2);
    serve_ball("serve_a");

    // Hit together with miss_r: the miss wins.
    event_pulse(1'b1, 1'b0, 1'b0);
    chk("rally1", 32'(bus.rally), 32'd1);
    event_pulse(1'b1, 1'b0, 1'b1);
    chk("hitmiss_score_l", 32'(bus.score_l),    32'd1);
    chk("hitmiss_rally",   32'(bus.rally),      32'd0);
    chk("hitmiss_serve",   32'(bus.serve_dir),  32'd1);
    chk("hitmiss_state",   32'(bus.state_code), 32'd2);
    serve_ball("serve_b");

    // Left player climbs to 4, then wins with the fifth point.
    for (int i = 0; i < 3; i++) begin
      event_pulse(1'b0, 1'b0, 1'b1);
      chk("climb_state", 32'(bus.state_code), 32'd2);
      serve_ball("serve_c");
    end
    chk("score_l4", 32'(bus.score_l), 32'd4);
    event_pulse(1'b0, 1'b0, 1'b1);
    chk("win_score_l", 32'(bus.score_l),     32'd5);
    chk("win_state",   32'(bus.state_code),  32'd3);
    chk("win_over",    32'(bus.game_over),   32'd1);
    chk("win_winner",  32'(bus.winner),      32'd0);
    chk("win_still",   32'(bus.graph_still), 32'd1);

    // Events during OVER are ignored.
    event_pulse(1'b1, 1'b1, 1'b0);
    chk("over_ign_rally",   32'(bus.rally),   32'd0);
    chk("over_ign_score_r", 32'(bus.score_r), 32'd1);
    refr_pulses(179);
    chk("over_179", 32'(bus.state_code), 32'd3);
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
    chk("over_180", 32'(bus.state_code), 32'd3);
    step();
    chk("over_exit_state", 32'(bus.state_code), 32'd0);
    chk("over_exit_go",    32'(bus.game_over),  32'd0);
    chk("over_keep_score", 32'(bus.score_l),    32'd5);

    // New game clears scores; build 2/3 and reset mid-play.
    bus.btn1 = 2'b10;
    step();
    bus.btn1 = 2'b00;
    chk("ng2_state",   32'(bus.state_code), 32'd1);
    chk("ng2_score_l", 32'(bus.score_l),    32'd0);
    chk("ng2_score_r", 32'(bus.score_r),    32'd0);
    for (int i = 0; i < 2; i++) begin
      event_pulse(1'b0, 1'b0, 1'b1);
      serve_ball("serve_d");
    end
    for (int i = 0; i < 3; i++) begin
      event_pulse(1'b0, 1'b1, 1'b0);
      serve_ball("serve_e");
    end
    event_pulse(1'b1, 1'b0, 1'b0);
    chk("pre_rst_score_l", 32'(bus.score_l), 32'd2);
    chk("pre_rst_score_r", 32'(bus.score_r), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state",   32'(bus.state_code),  32'd0);
    chk("arst_score_l", 32'(bus.score_l),     32'd0);
    chk("arst_score_r", 32'(bus.score_r),     32'd0);
    chk("arst_still",   32'(bus.graph_still), 32'd1);
    chk("arst_rally",   32'(bus.rally),       32'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
